// File: rtl/phase_accumulator_mc.sv
// Time-multiplexed multi-channel DDS phase accumulator: one shared adder serves
// NUM_CH channels round-robin and emits a (channel, phase, square, wrap) stream.
module phase_accumulator_mc #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned FREQ_W  = 24,
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned CH_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_wdata,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_square,
  output logic               out_wrap
);

  localparam int unsigned SUM_W = PHASE_W + 1;
  localparam logic [CH_W:0]       NUM_CH_X = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [DUTY_W-1:0]   DUTY_RST = DUTY_W'(2 ** (DUTY_W - 1));
  localparam bit                  SYNC_OK  = (NUM_CH > 1);

  logic [PHASE_W-1:0] phase_q   [NUM_CH];
  logic [PHASE_W-1:0] phase_d   [NUM_CH];
  logic [FREQ_W-1:0]  freq_q    [NUM_CH];
  logic [FREQ_W-1:0]  freq_d    [NUM_CH];
  logic [DUTY_W-1:0]  duty_q    [NUM_CH];
  logic [DUTY_W-1:0]  duty_d    [NUM_CH];
  logic [NUM_CH-1:0]  ch_en_q,   ch_en_d;
  logic [NUM_CH-1:0]  sync_en_q, sync_en_d;
  logic [NUM_CH-1:0]  pend_q,    pend_d;
  logic [CH_W-1:0]    p_q,       p_d;

  logic               out_valid_q,  out_valid_d;
  logic [CH_W-1:0]    out_ch_q,     out_ch_d;
  logic [PHASE_W-1:0] out_phase_q,  out_phase_d;
  logic               out_square_q, out_square_d;
  logic               out_wrap_q,   out_wrap_d;

  logic [CH_W-1:0]    p_nxt;
  logic               cfg_hit;
  logic               load_hit;
  logic [SUM_W-1:0]   sum;
  logic [PHASE_W-1:0] new_phase;
  logic               new_wrap;

  // Service update for channel p_q, then configuration writes layered on top.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      phase_d[i] = phase_q[i];
      freq_d[i]  = freq_q[i];
      duty_d[i]  = duty_q[i];
    end
    ch_en_d      = ch_en_q;
    sync_en_d    = sync_en_q;
    pend_d       = pend_q;
    p_d          = p_q;
    out_valid_d  = 1'b0;
    out_ch_d     = out_ch_q;
    out_phase_d  = out_phase_q;
    out_square_d = out_square_q;
    out_wrap_d   = out_wrap_q;

    p_nxt    = (p_q == LAST_CH) ? '0 : p_q + CH_W'(1);
    cfg_hit  = cfg_we && ({1'b0, cfg_ch} < NUM_CH_X);
    load_hit = cfg_hit && enable && (cfg_addr == 2'd3) && (cfg_ch == p_q);
    sum      = {1'b0, phase_q[p_q]} + SUM_W'(freq_q[p_q]);

    // A colliding phase load wins over the accumulator update.
    if (load_hit) begin
      new_phase = cfg_wdata;
      new_wrap  = 1'b0;
    end else if (!ch_en_q[p_q]) begin
      new_phase = phase_q[p_q];
      new_wrap  = 1'b0;
    end else if (SYNC_OK && sync_en_q[p_q] && pend_q[p_q]) begin
      new_phase = '0;
      new_wrap  = 1'b0;
    end else begin
      new_phase = sum[PHASE_W-1:0];
      new_wrap  = sum[PHASE_W];
    end

    if (enable) begin
      p_d            = p_nxt;
      phase_d[p_q]   = new_phase;
      if (load_hit || (SYNC_OK && ch_en_q[p_q] && sync_en_q[p_q] && pend_q[p_q]))
        pend_d[p_q]  = 1'b0;
      if (new_wrap)
        pend_d[p_nxt] = 1'b1;
      out_valid_d  = 1'b1;
      out_ch_d     = p_q;
      out_phase_d  = new_phase;
      out_square_d = (new_phase[PHASE_W-1 -: DUTY_W] < duty_q[p_q]);
      out_wrap_d   = new_wrap;
    end

    // Non-phase registers written here only affect the next service.
    if (cfg_hit) begin
      case (cfg_addr)
        2'd0: freq_d[cfg_ch] = cfg_wdata[FREQ_W-1:0];
        2'd1: duty_d[cfg_ch] = cfg_wdata[DUTY_W-1:0];
        2'd2: begin
          ch_en_d[cfg_ch]   = cfg_wdata[1];
          sync_en_d[cfg_ch] = cfg_wdata[0];
        end
        default: phase_d[cfg_ch] = cfg_wdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        phase_q[i] <= '0;
        freq_q[i]  <= '0;
        duty_q[i]  <= DUTY_RST;
      end
      ch_en_q      <= '1;
      sync_en_q    <= '0;
      pend_q       <= '0;
      p_q          <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_phase_q  <= '0;
      out_square_q <= 1'b0;
      out_wrap_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        phase_q[i] <= phase_d[i];
        freq_q[i]  <= freq_d[i];
        duty_q[i]  <= duty_d[i];
      end
      ch_en_q      <= ch_en_d;
      sync_en_q    <= sync_en_d;
      pend_q       <= pend_d;
      p_q          <= p_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_phase_q  <= out_phase_d;
      out_square_q <= out_square_d;
      out_wrap_q   <= out_wrap_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_phase  = out_phase_q;
  assign out_square = out_square_q;
  assign out_wrap   = out_wrap_q;

endmodule
